// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target: FSM encoding, ACK levels, byte width.
package i2c_pkg;

  localparam int   BYTE_W   = 8;
  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ADDR      = 3'd1,
    ADDR_ACK  = 3'd2,
    RX_DATA   = 3'd3,
    RX_ACK    = 3'd4,
    TX_DATA   = 3'd5,
    TX_ACK    = 3'd6,
    WAIT_STOP = 3'd7
  } state_t;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizes SCL/SDA into core_clk and derives SCL edges plus START/STOP strobes.
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic core_clk,
  input  logic rst,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic sda_s,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_s;
  logic                   scl_d;
  logic                   sda_d;

  // Idle bus is high, so the chain resets to 1 to avoid spurious edges
  always_ff @(posedge core_clk or posedge rst) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
    end
  end

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

endmodule

// File: rtl/i2c_slave.sv
// Single-address I2C target: push interface for written bytes, valid/ready pull for read bytes.
// Define I2C_SLAVE_CLK_STRETCH_EN to hold SCL low on a read underrun instead of sending 8'hFF.
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic              core_clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              scl_in,
  input  logic              sda_in,
  output logic              sda_oe,
  output logic              scl_oe,
  output logic [BYTE_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic [BYTE_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              busy
);

  logic scl_rise, scl_fall, sda_s, start_det, stop_det;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .core_clk  (core_clk),
    .rst       (rst),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .sda_s     (sda_s),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  state_t              state, state_n;
  logic [2:0]          bit_cnt, bit_cnt_n;
  logic [6:0]          shreg, shreg_n;
  logic [BYTE_W-1:0]   tx_byte, tx_byte_n, rx_data_n;
  logic                rw, rw_n, phase, phase_n, busy_n;
  logic                sda_oe_n, rx_valid_n, tx_ready_n, do_load;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
  logic                stretch, stretch_n, scl_rel, scl_rel_n, scl_oe_n;
`else
  assign scl_oe = 1'b0;
`endif

  always_ff @(posedge core_clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (!enable || stop_det) state_n = IDLE;
    else if (start_det)      state_n = ADDR;
    else begin
      case (state)
        ADDR:     if (scl_rise && bit_cnt == 3'd0)
                    state_n = (shreg == SLAVE_ADDR) ? ADDR_ACK : WAIT_STOP;
        ADDR_ACK: if (scl_fall && phase) state_n = rw ? TX_DATA : RX_DATA;
        RX_DATA:  if (scl_rise && bit_cnt == 3'd0) state_n = RX_ACK;
        RX_ACK:   if (scl_fall && phase) state_n = RX_DATA;
        TX_DATA:  if (scl_rise && bit_cnt == 3'd0) state_n = TX_ACK;
        TX_ACK:   if (scl_rise && sda_s == I2C_NACK) state_n = WAIT_STOP;
                  else if (scl_fall && phase)         state_n = TX_DATA;
        default:  ;
      endcase
    end
  end

  always_comb begin
    bit_cnt_n  = bit_cnt;
    shreg_n    = shreg;
    tx_byte_n  = tx_byte;
    rx_data_n  = rx_data;
    rw_n       = rw;
    phase_n    = phase;
    busy_n     = busy;
    sda_oe_n   = sda_oe;
    rx_valid_n = 1'b0;
    tx_ready_n = 1'b0;
    do_load    = 1'b0;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
    stretch_n  = stretch;
    scl_rel_n  = 1'b0;
    scl_oe_n   = scl_rel ? 1'b0 : scl_oe;
`endif
    // A completed write byte is delivered even if START/STOP lands on the same cycle
    if (enable && state == RX_DATA && scl_rise && bit_cnt == 3'd0) begin
      rx_data_n  = {shreg, sda_s};
      rx_valid_n = 1'b1;
    end
    if (!enable || stop_det || start_det) begin
      sda_oe_n  = 1'b0;
      bit_cnt_n = 3'd7;
      phase_n   = 1'b0;
      if (!enable || stop_det) busy_n = 1'b0;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
      stretch_n = 1'b0;
      scl_oe_n  = 1'b0;
`endif
    end else begin
      case (state)
        ADDR, RX_DATA: if (scl_rise) begin
          shreg_n = {shreg[5:0], sda_s};
          if (bit_cnt == 3'd0) begin
            bit_cnt_n = 3'd7;
            phase_n   = 1'b0;
            if (state == ADDR && shreg == SLAVE_ADDR) begin
              busy_n = 1'b1;
              rw_n   = sda_s;
            end
          end else begin
            bit_cnt_n = bit_cnt - 3'd1;
          end
        end
        ADDR_ACK, RX_ACK: if (scl_fall) begin
          if (!phase) begin
            sda_oe_n = 1'b1;
            phase_n  = 1'b1;
          end else begin
            sda_oe_n = 1'b0;
            phase_n  = 1'b0;
            do_load  = (state == ADDR_ACK) && rw;
          end
        end
        TX_DATA: begin
`ifdef I2C_SLAVE_CLK_STRETCH_EN
          if (stretch) begin
            if (tx_valid) begin
              tx_byte_n  = tx_data;
              tx_ready_n = 1'b1;
              sda_oe_n   = ~tx_data[BYTE_W-1];
              stretch_n  = 1'b0;
              scl_rel_n  = 1'b1;
            end
          end else
`endif
          if (scl_rise) begin
            if (bit_cnt == 3'd0) begin
              bit_cnt_n = 3'd7;
              phase_n   = 1'b0;
            end else begin
              bit_cnt_n = bit_cnt - 3'd1;
            end
          end else if (scl_fall) begin
            sda_oe_n = ~tx_byte[bit_cnt];
          end
        end
        TX_ACK: if (scl_rise) begin
          phase_n = 1'b1;
        end else if (scl_fall) begin
          if (!phase) sda_oe_n = 1'b0;
          else begin
            phase_n = 1'b0;
            do_load = 1'b1;
          end
        end
        default: ;
      endcase
    end
    // Load point: the SCL fall that ends an ACK bit also drives the first data bit
    if (do_load) begin
      bit_cnt_n = 3'd7;
      if (tx_valid) begin
        tx_byte_n  = tx_data;
        tx_ready_n = 1'b1;
        sda_oe_n   = ~tx_data[BYTE_W-1];
      end else begin
`ifdef I2C_SLAVE_CLK_STRETCH_EN
        stretch_n = 1'b1;
        scl_oe_n  = 1'b1;
        sda_oe_n  = 1'b0;
`else
        tx_byte_n = 8'hFF;
        sda_oe_n  = 1'b0;
`endif
      end
    end
  end

  always_ff @(posedge core_clk or posedge rst) begin
    if (rst) begin
      bit_cnt  <= 3'd7;
      rw       <= 1'b0;
      phase    <= 1'b0;
      busy     <= 1'b0;
      sda_oe   <= 1'b0;
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      tx_ready <= 1'b0;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
      stretch  <= 1'b0;
      scl_rel  <= 1'b0;
      scl_oe   <= 1'b0;
`endif
    end else begin
      bit_cnt  <= bit_cnt_n;
      rw       <= rw_n;
      phase    <= phase_n;
      busy     <= busy_n;
      sda_oe   <= sda_oe_n;
      rx_data  <= rx_data_n;
      rx_valid <= rx_valid_n;
      tx_ready <= tx_ready_n;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
      stretch  <= stretch_n;
      scl_rel  <= scl_rel_n;
      scl_oe   <= scl_oe_n;
`endif
    end
  end

  always_ff @(posedge core_clk) begin
    shreg   <= shreg_n;
    tx_byte <= tx_byte_n;
  end

endmodule

// File: doc/i2c_slave.md
Name: i2c_slave

Overview:
Single-address I2C target (responder) that talks to the team's I2C master controller over the shared open-drain SCL/SDA bus.
- Oversamples SCL/SDA on core_clk.
- Detects START, repeated START and STOP, and matches a 7-bit address.
- Write transfers: receives bytes into a byte-wide push interface.
- Read transfers: sources bytes from a valid/ready pull interface.
- Sits between the bus pads and the slave-side FIFOs.

Parameters:
- SLAVE_ADDR, 7'h50, 7-bit address this target responds to.
- SYNC_STAGES, 2, synchronizer flops on scl_in/sda_in (minimum 2).

Ports:
- core_clk  in  1  sole clock; must run at least 8x the SCL rate.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  0 forces IDLE and releases the bus.
- scl_in  in  1  bus SCL level.
- sda_in  in  1  bus SDA level.
- sda_oe  out  1  1 = pull SDA low; 0 = release.
- scl_oe  out  1  1 = pull SCL low (stretch); constant 0 without the optional feature.
- rx_data  out  8  last received write byte.
- rx_valid  out  1  one-cycle pulse; rx_data is new.
- tx_data  in  8  next read byte.
- tx_valid  in  1  tx_data is available.
- tx_ready  out  1  one-cycle pulse; tx_data consumed this cycle.
- busy  out  1  high from an address match until STOP or abort.

Behaviour:
- Clock and reset: one clock, core_clk. Reset is asynchronous, active-high (rst).
- Reset values: sda_oe=0, scl_oe=0, rx_data=8'h00, rx_valid=0, tx_ready=0, busy=0, state=IDLE, bit counter=7.
- Line conditioning:
  - Synchronize scl_in/sda_in; register the synchronized copies for edge detect.
  - scl_rise/scl_fall come from the synchronized SCL.
  - START = sda falling while SCL high. STOP = sda rising while SCL high.
  - Detect latency: SYNC_STAGES+1 cycles after the bus event.
- Timing rules:
  - Sample SDA only on scl_rise.
  - Change sda_oe only on scl_fall, or on START/STOP/abort.
- States: IDLE, ADDR, ADDR_ACK, RX_DATA, RX_ACK, TX_DATA, TX_ACK, WAIT_STOP.
- Global transitions (highest priority first):
  - enable=0 or rst -> IDLE, sda_oe=0 immediately.
  - STOP -> IDLE, busy=0.
  - START (any state, including mid-byte) -> ADDR, counter=7, sda_oe=0.
- ADDR:
  - Shift 8 bits MSB first on scl_rise.
  - After the 8th bit: if addr[7:1]==SLAVE_ADDR, set busy=1, latch rw=bit0, go to ADDR_ACK; otherwise go to WAIT_STOP.
- ADDR_ACK:
  - Assert sda_oe on the next scl_fall; hold through one SCL high.
  - On the following scl_fall, release sda_oe.
  - rw=0 -> RX_DATA.
  - rw=1 -> load the TX byte, then go to TX_DATA.
- TX byte load:
  - tx_valid=1 -> take tx_data and pulse tx_ready.
  - tx_valid=0 -> send 8'hFF, no tx_ready.
- RX_DATA:
  - Shift 8 bits on scl_rise.
  - On the 8th rise, rx_data <= byte and pulse rx_valid the next cycle. Then RX_ACK.
- RX_ACK:
  - Always ACK: drive sda_oe=1 on scl_fall, release on the next scl_fall.
  - Return to RX_DATA with counter=7.
- TX_DATA:
  - On each scl_fall, sda_oe = ~bit[counter].
  - After 8 bits, release sda_oe on scl_fall and go to TX_ACK.
- TX_ACK:
  - Sample SDA on scl_rise.
  - 0 (ACK): load the next byte on scl_fall, go to TX_DATA.
  - 1 (NACK): WAIT_STOP with sda_oe=0.
- WAIT_STOP: ignore the bus until START or STOP.
- Pulse rules:
  - rx_valid and tx_ready are never high on the same cycle and never more than 1 cycle.
  - A pending rx_valid is still issued if START or STOP coincides with the 8th rise.
- Counter: 3-bit, decrements on scl_rise in the shift states. Wrap at 0 only by explicit reload to 7.

Optional Feature:
- Macro I2C_SLAVE_CLK_STRETCH_EN.
- Defined:
  - If tx_valid=0 at a TX load point, assert scl_oe on the scl_fall that ends the ACK bit.
  - Hold scl_oe until tx_valid=1. Then take the byte, pulse tx_ready, drive the first bit on sda_oe, and release scl_oe one cycle later.
  - START/STOP/enable=0/rst release scl_oe immediately.
- Undefined:
  - scl_oe tied 0; an underrun sends 8'hFF.

Decomposition:
- Package i2c_pkg holds:
  - state enum encoding;
  - I2C_ACK=1'b0 and I2C_NACK=1'b1;
  - BYTE_W=8.
- Sub-module i2c_line_sync:
  - synchronizers and edge registers;
  - outputs scl_rise, scl_fall, sda_s, start_det, stop_det.

Test Plan:
- Master writes addr 0x50+W, data 8'hA5, 8'h3C, STOP -> ACK on all 3 bytes; rx_valid pulses twice with A5 then 3C; busy falls after STOP.
- Master sends addr 0x51+W -> SDA never driven, no rx_valid, busy stays 0; the next START to 0x50 is accepted.
- Read from 0x50 with tx_data=8'hC3, tx_valid=1; master ACKs byte 1 and NACKs byte 2 (tx_data=8'h81) -> bus shows C3 then 81; two tx_ready pulses; WAIT_STOP then IDLE.
- Write 0x50, data 8'h12, repeated START, read 0x50 -> rx_valid with 12, then a correct read byte; no STOP needed between.
- STOP after 4 data bits, and rst asserted mid TX_DATA -> sda_oe=0 within 1 cycle of rst (async) or SYNC_STAGES+1 cycles of STOP; no rx_valid.
- With I2C_SLAVE_CLK_STRETCH_EN, read with tx_valid=0 for 50 cycles -> scl_oe=1 for that span; byte 8'h5A then sent intact.
